hit_capture_reg: RTL and testbench

//  Parametrised multi-channel hit latch for the trigger front end. It synchronises

---
 rtl/hit_reg_pkg.sv | 18 +
 rtl/hit_chan.sv | 58 +++++
 rtl/hit_capture_reg.sv | 73 +++++++
 tb/tb_hit_capture_reg.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hit_reg_pkg.sv
// Shared types and helpers for the hit capture register and its per-channel slice.
package hit_reg_pkg;
  typedef enum logic [1:0] {
    EDGE_RISE  = 2'b00,
    EDGE_FALL  = 2'b01,
    EDGE_BOTH  = 2'b10,
    EDGE_LEVEL = 2'b11
  } edge_mode_t;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_t;

  function automatic int hold_w(input int hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction
endpackage

// File: rtl/hit_chan.sv
// One hit channel: input synchroniser, edge detect, latched Q with hold timer, sticky pile-up.
module hit_chan
  import hit_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit,
  input  logic       mask,
  input  edge_mode_t edge_mode,
  input  logic       auto_clr,
  input  logic       clr,
  input  logic       snap_clr,
  output logic       q,
  output logic       pileup
);
  localparam int            CW       = hold_w(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   h, s, ev_raw, ev, expire, clear;
  logic [CW-1:0]          cnt;

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    case (edge_mode)
      EDGE_RISE: ev_raw = s & ~h;
      EDGE_FALL: ev_raw = ~s & h;
      EDGE_BOTH: ev_raw = s ^ h;
      default:   ev_raw = s;
    endcase
  end

  assign ev     = ev_raw & mask;
  assign expire = auto_clr & q & (cnt == '0);
  assign clear  = clr | expire | snap_clr;

  // A set always wins over any clear so a hit landing on a clear is never dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      h      <= 1'b0;
      q      <= 1'b0;
      pileup <= 1'b0;
      cnt    <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], hit};
      h      <= s;
      q      <= ev | (q & ~clear);
      pileup <= (ev & q & ~clear) | (pileup & ~clr);
      if (ev)                   cnt <= CNT_LOAD;
      else if (q && cnt != '0)  cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/hit_capture_reg.sv
// Multi-channel hit latch with req/ack snapshot readout and optional clear-on-read.
module hit_capture_reg
  import hit_reg_pkg::*;
#(
  parameter int WIDTH       = 48,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int CLR_ON_READ = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] hit_in,
  input  logic [WIDTH-1:0] mask,
  input  logic [1:0]       edge_mode,
  input  logic             auto_clr,
  input  logic [WIDTH-1:0] clr,
  input  logic             rd_req,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] pileup,
  output logic             any_hit,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data
);
  rd_state_t        state;
  logic             rd_take;
  logic [WIDTH-1:0] snap_clr;
  edge_mode_t       mode;

  assign mode     = edge_mode_t'(edge_mode);
  assign rd_take  = (state == RD_IDLE) & rd_req;
  assign snap_clr = {WIDTH{rd_take && (CLR_ON_READ != 0)}} & Q;
  assign any_hit  = |Q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    hit_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .hit      (hit_in[i]),
      .mask     (mask[i]),
      .edge_mode(mode),
      .auto_clr (auto_clr),
      .clr      (clr[i]),
      .snap_clr (snap_clr[i]),
      .q        (Q[i]),
      .pileup   (pileup[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RD_IDLE;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        RD_IDLE: if (rd_req) begin
          state    <= RD_VALID;
          rd_valid <= 1'b1;
          rd_data  <= Q;
        end
        RD_VALID: if (rd_ack) begin
          state    <= RD_IDLE;
          rd_valid <= 1'b0;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hit_capture_reg.sv
// Bench for hit_capture_reg: directed table, corner sequences, then randomized run vs a reference model.
module tb_hit_capture_reg;
  localparam int W  = 48;
  localparam int SS = 2;
  localparam int HC = 4;
  localparam int COR = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] hit_in, mask, clr;
  logic [1:0]   edge_mode;
  logic         auto_clr, rd_req, rd_ack;
  logic [W-1:0] Q, pileup, rd_data;
  logic         any_hit, rd_valid;

  always #5 clk = ~clk;

  hit_capture_reg #(.WIDTH(W), .SYNC_STAGES(SS), .HOLD_CYCLES(HC), .CLR_ON_READ(COR)) dut (
    .clk(clk), .rst_n(rst_n), .hit_in(hit_in), .mask(mask), .edge_mode(edge_mode),
    .auto_clr(auto_clr), .clr(clr), .rd_req(rd_req), .rd_ack(rd_ack), .Q(Q),
    .pileup(pileup), .any_hit(any_hit), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  int vecs = 0;
  int miss = 0;

  // Reference model: input history as a delay line, hold as "cycles of Q left".
  logic [W-1:0] m_q, m_pile, m_data;
  logic         m_valid;
  int           m_rem [W];
  logic [W-1:0] m_hist [SS+1];

  typedef struct {
    logic [W-1:0] hit;
    logic [W-1:0] clr;
    logic         req;
    logic         ack;
    logic [W-1:0] eq;
    logic         ev;
    logic [W-1:0] ed;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_q = '0; m_pile = '0; m_data = '0; m_valid = 1'b0;
    for (int i = 0; i < W; i++) m_rem[i] = 0;
    for (int k = 0; k <= SS; k++) m_hist[k] = '0;
  endfunction

  function automatic void model_edge();
    logic [W-1:0] s, h, ev, snap, nq, np;
    logic         expd, clr_any;
    s = m_hist[SS-1];
    h = m_hist[SS];
    case (edge_mode)
      2'b00:   ev = s & ~h;
      2'b01:   ev = ~s & h;
      2'b10:   ev = s ^ h;
      default: ev = s;
    endcase
    ev   = ev & mask;
    snap = (!m_valid && rd_req && COR != 0) ? m_q : '0;
    for (int i = 0; i < W; i++) begin
      expd    = auto_clr && m_q[i] && (m_rem[i] == 1);
      clr_any = clr[i] || expd || snap[i];
      nq[i]   = ev[i] ? 1'b1 : (clr_any ? 1'b0 : m_q[i]);
      np[i]   = (ev[i] && m_q[i] && !clr_any) || (m_pile[i] && !clr[i]);
      if (ev[i])                         m_rem[i] = HC;
      else if (m_q[i] && m_rem[i] > 1)   m_rem[i] = m_rem[i] - 1;
    end
    if (!m_valid && rd_req) begin
      m_data  = m_q;
      m_valid = 1'b1;
    end else if (m_valid && rd_ack) begin
      m_valid = 1'b0;
    end
    m_q    = nq;
    m_pile = np;
    for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = hit_in;
  endfunction

  task automatic check_all();
    chk("Q", Q, m_q);
    chk("pileup", pileup, m_pile);
    chk("any_hit", W'(any_hit), W'(|m_q));
    chk("rd_valid", W'(rd_valid), W'(m_valid));
    chk("rd_data", rd_data, m_data);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic void add(input logic [W-1:0] hit, input logic [W-1:0] c, input logic req,
                              input logic ack, input logic [W-1:0] eq, input logic ev,
                              input logic [W-1:0] ed);
    vec_t v;
    v.hit = hit; v.clr = c; v.req = req; v.ack = ack; v.eq = eq; v.ev = ev; v.ed = ed;
    tbl.push_back(v);
  endfunction

  logic [15:0] trace;

  initial begin
    rst_n = 1'b0; hit_in = '0; mask = '1; clr = '0; edge_mode = 2'b00;
    auto_clr = 1'b0; rd_req = 1'b0; rd_ack = 1'b0;
    model_reset();
    #22;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single pulse on ch3, clear; snapshot of 0x81 with clear-on-read and hold-through-idle.
    add(W'(8),    '0,     0, 0, '0,      0, '0);
    add('0,       '0,     0, 0, '0,      0, '0);
    add('0,       '0,     0, 0, W'(8),   0, '0);
    add('0,       '0,     0, 0, W'(8),   0, '0);
    add('0,       W'(8),  0, 0, '0,      0, '0);
    add('0,       '0,     0, 0, '0,      0, '0);
    add(W'('h81), '0,     0, 0, '0,      0, '0);
    add('0,       '0,     0, 0, '0,      0, '0);
    add('0,       '0,     0, 0, W'('h81), 0, '0);
    add('0,       '0,     1, 0, '0,      1, W'('h81));
    for (int k = 0; k < 10; k++) add('0, '0, (k == 3), 0, '0, 1, W'('h81));
    add('0,       '0,     0, 1, '0,      0, W'('h81));
    add('0,       '0,     0, 1, '0,      0, W'('h81));
    foreach (tbl[r]) begin
      hit_in = tbl[r].hit; clr = tbl[r].clr; rd_req = tbl[r].req; rd_ack = tbl[r].ack;
      tick();
      chk($sformatf("tbl%0d_q", r), Q, tbl[r].eq);
      chk($sformatf("tbl%0d_valid", r), W'(rd_valid), W'(tbl[r].ev));
      chk($sformatf("tbl%0d_data", r), rd_data, tbl[r].ed);
    end
    hit_in = '0; clr = '0; rd_req = 1'b0; rd_ack = 1'b0;
    tick();

    // Auto-clear hold length, then retrigger two cycles later with pile-up.
    auto_clr = 1'b1;
    trace = '0;
    for (int t = 1; t <= 12; t++) begin
      hit_in = W'(t == 1);
      tick();
      trace[t] = Q[0];
    end
    chk("hold_single", W'(trace), W'(16'b0000_0000_0111_1000));
    trace = '0;
    for (int t = 1; t <= 12; t++) begin
      hit_in = W'(t == 1 || t == 3);
      tick();
      trace[t] = Q[0];
    end
    chk("hold_retrig", W'(trace), W'(16'b0000_0001_1111_1000));
    chk("pileup0", W'(pileup[0]), W'(1));

    // Both-edge mode: a 5-cycle pulse gives two events; masked, none.
    auto_clr = 1'b0; edge_mode = 2'b10; hit_in = '0; clr = '1;
    tick();
    clr = '0;
    for (int t = 1; t <= 10; t++) begin
      hit_in = (t <= 5) ? (W'(1) << 47) : '0;
      tick();
    end
    chk("both_q47", W'(Q[47]), W'(1));
    chk("both_pile47", W'(pileup[47]), W'(1));
    clr = W'(1) << 47; mask[47] = 1'b0;
    tick();
    clr = '0;
    for (int t = 1; t <= 10; t++) begin
      hit_in = (t <= 5) ? (W'(1) << 47) : '0;
      tick();
    end
    chk("mask_q47", W'(Q[47]), W'(0));
    chk("mask_pile47", W'(pileup[47]), W'(0));
    mask = '1;

    // Set on ch5 coincides with clr[5] and a snapshot clear.
    edge_mode = 2'b00; clr = '1;
    tick();
    clr = '0;
    hit_in = W'(32); tick();
    hit_in = '0;     tick();
    tick();
    hit_in = W'(32); tick();
    hit_in = '0;     tick();
    clr = W'(32); rd_req = 1'b1;
    tick();
    clr = '0; rd_req = 1'b0;
    chk("coll_q5", W'(Q[5]), W'(1));
    chk("coll_data5", W'(rd_data[5]), W'(1));
    chk("coll_pile5", W'(pileup[5]), W'(0));
    chk("coll_valid", W'(rd_valid), W'(1));

    // Async reset while a snapshot is pending.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(rd_valid), W'(0));
    chk("arst_q", Q, '0);
    chk("arst_pile", pileup, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      hit_in = hit_in ^ (rnd() & rnd() & rnd());
      mask   = ~(rnd() & rnd() & rnd());
      clr    = rnd() & rnd() & rnd() & rnd();
      if ($urandom_range(0, 63) == 0) edge_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) auto_clr = 1'($urandom_range(0, 1));
      rd_req = ($urandom_range(0, 3) == 0);
      rd_ack = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
